// File: rtl/ck_ram_pkg.sv
// Shared constants and the fixed-priority-with-anti-starvation grant rule
// used by the IFU/LSU RAM arbiter.
package ck_ram_pkg;

    localparam int PORT_IFU  = 0;
    localparam int PORT_LSU  = 1;
    localparam int NUM_PORTS = 2;

    localparam int STARVE_W = 4;
    typedef logic [STARVE_W-1:0] starve_t;

    typedef logic [NUM_PORTS-1:0] grant_t;

    // LSU has priority unless IFU has been denied long enough to be forced through.
    function automatic grant_t arbitrate(input logic ifu_elig,
                                         input logic lsu_elig,
                                         input logic ifu_forced);
        grant_t g;
        g           = '0;
        g[PORT_LSU] = lsu_elig && !(ifu_elig && ifu_forced);
        g[PORT_IFU] = ifu_elig && !g[PORT_LSU];
        return g;
    endfunction

endpackage

// File: rtl/ram_rsp_skid.sv
// Per-port response path: tracks the one-cycle-late RAM read, and parks the
// data in a hold register while the consumer applies backpressure.
module ram_rsp_skid #(
    parameter int DATA_WHITH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  grant,
    input  logic [DATA_WHITH-1:0] ram_rdata,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic [DATA_WHITH-1:0] rsp_rdata,
    output logic                  eligible
);

    logic                  in_flight;
    logic                  hold_valid;
    logic [DATA_WHITH-1:0] hold_data;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight  <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            in_flight <= grant;
            if (in_flight && !rsp_ready) begin
                hold_valid <= 1'b1;
            end else if (hold_valid && rsp_ready) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // NOTE: the hold data register is deliberately left without reset; it is
    // only ever observed while hold_valid (which is reset) is set.
    always_ff @(posedge clk) begin
        if (in_flight && !rsp_ready) begin
            hold_data <= ram_rdata;
        end
    end

    // The RAM read data is only valid in the cycle after the grant, so it is
    // forwarded directly then and served from the hold register afterwards.
    assign rsp_valid = in_flight || hold_valid;
    assign rsp_rdata = hold_valid ? hold_data : ram_rdata;

    // A new grant is allowed as soon as any pending response leaves this cycle.
    assign eligible  = !rsp_valid || rsp_ready;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port byte-writable RAM between instruction fetch (read
// only) and load/store, one access per cycle, with per-port response buffering.
module ram_arbiter
    import ck_ram_pkg::*;
#(
    parameter int DATA_WHITH = 32,
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_WHITH = 10,
    parameter int DATA_BYTE  = DATA_WHITH / DATA_SIZE,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WHITH-1:0] ifu_req_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_WHITH-1:0] ifu_rsp_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WHITH-1:0] lsu_req_addr,
    input  logic [DATA_BYTE-1:0]  lsu_req_we,
    input  logic [DATA_WHITH-1:0] lsu_req_wdata,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_WHITH-1:0] lsu_rsp_rdata,

    output logic                  ram_cs,
    output logic [DATA_BYTE-1:0]  ram_we,
    output logic [ADDR_WHITH-1:0] ram_addr,
    output logic [DATA_WHITH-1:0] ram_wdata,
    input  logic [DATA_WHITH-1:0] ram_rdata
);

    localparam starve_t STARVE_LIMIT = starve_t'(STARVE_MAX);

    logic    init_done;
    logic    ifu_ok;
    logic    lsu_ok;
    logic    ifu_elig;
    logic    lsu_elig;
    grant_t  grant;
    starve_t starve_cnt;

    ram_rsp_skid #(
        .DATA_WHITH (DATA_WHITH)
    ) u_ifu_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (grant[PORT_IFU]),
        .ram_rdata (ram_rdata),
        .rsp_ready (ifu_rsp_ready),
        .rsp_valid (ifu_rsp_valid),
        .rsp_rdata (ifu_rsp_rdata),
        .eligible  (ifu_ok)
    );

    ram_rsp_skid #(
        .DATA_WHITH (DATA_WHITH)
    ) u_lsu_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (grant[PORT_LSU]),
        .ram_rdata (ram_rdata),
        .rsp_ready (lsu_rsp_ready),
        .rsp_valid (lsu_rsp_valid),
        .rsp_rdata (lsu_rsp_rdata),
        .eligible  (lsu_ok)
    );

    // Holds off all grants until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    assign ifu_elig = init_done && ifu_req_valid && ifu_ok;
    assign lsu_elig = init_done && lsu_req_valid && lsu_ok;
    assign grant    = arbitrate(ifu_elig, lsu_elig, starve_cnt == STARVE_LIMIT);

    assign ifu_req_ready = grant[PORT_IFU];
    assign lsu_req_ready = grant[PORT_LSU];

    // Counts consecutive cycles in which IFU could have gone but LSU took the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!ifu_req_valid || grant[PORT_IFU]) begin
            starve_cnt <= '0;
        end else if (ifu_elig && starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through it leaves a signal unassigned and no latch is inferred.
    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant[PORT_LSU]) begin
            ram_cs    = 1'b1;
            ram_we    = lsu_req_we;
            ram_addr  = lsu_req_addr;
            ram_wdata = lsu_req_wdata;
        end else if (grant[PORT_IFU]) begin
            ram_cs    = 1'b1;
            ram_addr  = ifu_req_addr;
            ram_wdata = lsu_req_wdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: reset, table vectors, directed corner
// sequences, and a randomized run against a queue-based reference model.
module tb_ram_arbiter;

    localparam int DW   = 32;
    localparam int DS   = 8;
    localparam int AW   = 10;
    localparam int NB   = DW / DS;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [AW-1:0] ifu_req_addr;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
    logic [AW-1:0] lsu_req_addr;
    logic [NB-1:0] lsu_req_we;
    logic [DW-1:0] lsu_req_wdata, lsu_rsp_rdata;
    logic          ram_cs;
    logic [NB-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_arbiter #(
        .DATA_WHITH (DW),
        .DATA_SIZE  (DS),
        .ADDR_WHITH (AW),
        .DATA_BYTE  (NB),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_rdata (ifu_rsp_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_we    (lsu_req_we),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    // Behavioural RAM macro: registered read, byte-masked write, writes return 0.
    logic [DW-1:0] mem     [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] ram_word;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we != '0) begin
                ram_word = mem[ram_addr];
                for (int b = 0; b < NB; b++)
                    if (ram_we[b]) ram_word[b*DS +: DS] = ram_wdata[b*DS +: DS];
                mem[ram_addr] = ram_word;
                ram_rdata <= '0;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end else begin
            ram_rdata <= '0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ref_write(input logic [AW-1:0] a, input logic [NB-1:0] we, input logic [DW-1:0] d);
        for (int b = 0; b < NB; b++)
            if (we[b]) ref_mem[a][b*DS +: DS] = d[b*DS +: DS];
    endtask

    task automatic drive(input logic iv, input logic [AW-1:0] ia,
                         input logic lv, input logic [NB-1:0] lwe,
                         input logic [AW-1:0] la, input logic [DW-1:0] lwd);
        ifu_req_valid = iv;
        ifu_req_addr  = ia;
        lsu_req_valid = lv;
        lsu_req_we    = lwe;
        lsu_req_addr  = la;
        lsu_req_wdata = lwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          iv;
        logic [AW-1:0] ia;
        logic          lv;
        logic [NB-1:0] lwe;
        logic [AW-1:0] la;
        logic [DW-1:0] lwd;
        logic          e_cs;
        logic [NB-1:0] e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_iready;
        logic          e_lready;
    } vec_t;

    vec_t vecs[8];

    // Reference model state for the randomized phase.
    logic [DW-1:0] q_ifu[$];
    logic [DW-1:0] q_lsu[$];
    int            starve;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        logic          ok_i, ok_l, g_i, g_l;

        for (int i = 0; i < (1 << AW); i++) begin
            v          = $urandom;
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[10'h010] = 32'hDEADBEEF; ref_mem[10'h010] = 32'hDEADBEEF;
        mem[10'h020] = 32'h11223344; ref_mem[10'h020] = 32'h11223344;

        vecs[0] = '{1'b0, 10'h000, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b1, 10'h011, 1'b0, 4'h0, 10'h000, 32'h55,       1'b1, 4'h0, 10'h011, 32'h55,       1'b1, 1'b0};
        vecs[2] = '{1'b0, 10'h000, 1'b1, 4'h0, 10'h030, 32'h0,        1'b1, 4'h0, 10'h030, 32'h0,        1'b0, 1'b1};
        vecs[3] = '{1'b0, 10'h000, 1'b1, 4'hF, 10'h040, 32'hCAFEF00D, 1'b1, 4'hF, 10'h040, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 10'h012, 1'b1, 4'h0, 10'h031, 32'h0,        1'b1, 4'h0, 10'h031, 32'h0,        1'b0, 1'b1};
        vecs[5] = '{1'b1, 10'h012, 1'b0, 4'h0, 10'h000, 32'h0,        1'b1, 4'h0, 10'h012, 32'h0,        1'b1, 1'b0};
        vecs[6] = '{1'b1, 10'h013, 1'b1, 4'h8, 10'h041, 32'h77000000, 1'b1, 4'h8, 10'h041, 32'h77000000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 10'h000, 1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 4'h0, 10'h000, 32'h0,        1'b0, 1'b0};

        // Reset: requests pending throughout, nothing may be granted early.
        rst_n         = 1'b0;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;
        drive(1'b1, 10'h010, 1'b1, 4'h0, 10'h020, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_cs", ram_cs, 1'b0);
            check("reset_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
            check("reset_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_release_cs", ram_cs, 1'b0);
        check("post_release_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("first_grant_cs", ram_cs, 1'b1);
        check("first_grant_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
        next_cycle();
        drive(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        next_cycle();

        // Table vectors: request-side decode with both consumers always ready.
        foreach (vecs[k]) begin
            next_cycle();
            drive(vecs[k].iv, vecs[k].ia, vecs[k].lv, vecs[k].lwe, vecs[k].la, vecs[k].lwd);
            @(negedge clk);
            check($sformatf("vec%0d_cs", k), ram_cs, vecs[k].e_cs);
            check($sformatf("vec%0d_we", k), ram_we, vecs[k].e_we);
            check($sformatf("vec%0d_addr", k), ram_addr, vecs[k].e_addr);
            check($sformatf("vec%0d_wdata", k), ram_wdata, vecs[k].e_wdata);
            check($sformatf("vec%0d_ready", k), {ifu_req_ready, lsu_req_ready},
                  {vecs[k].e_iready, vecs[k].e_lready});
            if (vecs[k].e_lready) ref_write(vecs[k].la, vecs[k].lwe, vecs[k].lwd);
        end

        // IFU-only read with one-cycle latency.
        next_cycle();
        drive(1'b1, 10'h010, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        check("ifu_read_grant", {ram_cs, ram_we, ifu_req_ready}, {1'b1, 4'h0, 1'b1});
        next_cycle();
        drive(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        check("ifu_read_valid", ifu_rsp_valid, 1'b1);
        check("ifu_read_data", ifu_rsp_rdata, 32'hDEADBEEF);

        // LSU byte write followed immediately by a read of the same word.
        next_cycle();
        drive(1'b0, 10'h0, 1'b1, 4'b0010, 10'h020, 32'h0000AB00);
        @(negedge clk);
        check("lsu_write_grant", {lsu_req_ready, ram_we}, {1'b1, 4'b0010});
        ref_write(10'h020, 4'b0010, 32'h0000AB00);
        next_cycle();
        drive(1'b0, 10'h0, 1'b1, 4'h0, 10'h020, 32'h0);
        @(negedge clk);
        check("lsu_write_ack", {lsu_rsp_valid, lsu_rsp_rdata}, {1'b1, 32'h0});
        check("lsu_read_grant", lsu_req_ready, 1'b1);
        next_cycle();
        drive(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        check("lsu_read_back", {lsu_rsp_valid, lsu_rsp_rdata}, {1'b1, 32'h1122AB44});

        // Contention: IFU is forced through after STARVE_MAX straight losses.
        next_cycle();
        drive(1'b1, 10'h010, 1'b1, 4'h0, 10'h020, 32'h0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("contend_%0d", i), {ifu_req_ready, lsu_req_ready},
                  ((i % (SMAX + 1)) == SMAX) ? 2'b10 : 2'b01);
            next_cycle();
        end
        drive(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        next_cycle();

        // Backpressure on IFU while LSU keeps using the RAM.
        next_cycle();
        ifu_rsp_ready = 1'b0;
        drive(1'b1, 10'h010, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        check("bp_ifu_grant", ifu_req_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b1, 10'h010, 1'b1, 4'h0, 10'h020, 32'h0);
            @(negedge clk);
            check($sformatf("bp_hold_%0d", i), {ifu_rsp_valid, ifu_rsp_rdata}, {1'b1, 32'hDEADBEEF});
            check($sformatf("bp_ready_%0d", i), {ifu_req_ready, lsu_req_ready}, 2'b01);
        end
        next_cycle();
        ifu_rsp_ready = 1'b1;
        drive(1'b1, 10'h010, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        check("bp_drain_data", {ifu_rsp_valid, ifu_rsp_rdata}, {1'b1, 32'hDEADBEEF});
        check("bp_drain_grant", ifu_req_ready, 1'b1);
        check("bp_lsu_rsp", {lsu_rsp_valid, lsu_rsp_rdata}, {1'b1, 32'h1122AB44});
        next_cycle();
        drive(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        @(negedge clk);
        check("bp_after_drain", {ifu_rsp_valid, ifu_rsp_rdata}, {1'b1, 32'hDEADBEEF});
        next_cycle();
        @(negedge clk);
        check("bp_idle", ifu_rsp_valid, 1'b0);

        // Reset while an LSU read is in flight.
        next_cycle();
        drive(1'b0, 10'h0, 1'b1, 4'h0, 10'h020, 32'h0);
        @(negedge clk);
        check("rst_mid_grant", lsu_req_ready, 1'b1);
        next_cycle();
        drive(1'b0, 10'h0, 1'b0, 4'h0, 10'h0, 32'h0);
        check("rst_mid_inflight", lsu_rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cleared", lsu_rsp_valid, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_mid_stale_%0d", i), {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
            next_cycle();
        end

        // Randomized traffic against the queue-based reference model.
        starve = 0;
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            drive($urandom_range(3) != 0, AW'($urandom_range(31)),
                  $urandom_range(3) != 0,
                  ($urandom_range(1) != 0) ? NB'($urandom_range(15)) : '0,
                  AW'($urandom_range(31)), $urandom);
            ifu_rsp_ready = $urandom_range(3) != 0;
            lsu_rsp_ready = $urandom_range(3) != 0;
            @(negedge clk);

            ok_i = ifu_req_valid && (q_ifu.size() == 0 || ifu_rsp_ready);
            ok_l = lsu_req_valid && (q_lsu.size() == 0 || lsu_rsp_ready);
            g_l  = ok_l && !(ok_i && starve == SMAX);
            g_i  = ok_i && !g_l;

            check("rnd_ready", {ifu_req_ready, lsu_req_ready}, {g_i, g_l});
            check("rnd_cs", ram_cs, g_i || g_l);
            check("rnd_we", ram_we, g_l ? lsu_req_we : '0);
            check("rnd_addr", ram_addr, g_l ? lsu_req_addr : (g_i ? ifu_req_addr : '0));
            check("rnd_ifu_valid", ifu_rsp_valid, q_ifu.size() != 0);
            check("rnd_lsu_valid", lsu_rsp_valid, q_lsu.size() != 0);
            if (q_ifu.size() != 0) check("rnd_ifu_data", ifu_rsp_rdata, q_ifu[0]);
            if (q_lsu.size() != 0) check("rnd_lsu_data", lsu_rsp_rdata, q_lsu[0]);

            if (q_ifu.size() != 0 && ifu_rsp_ready) void'(q_ifu.pop_front());
            if (q_lsu.size() != 0 && lsu_rsp_ready) void'(q_lsu.pop_front());
            if (g_l) begin
                if (lsu_req_we != '0) begin
                    ref_write(lsu_req_addr, lsu_req_we, lsu_req_wdata);
                    q_lsu.push_back('0);
                end else begin
                    q_lsu.push_back(ref_mem[lsu_req_addr]);
                end
            end
            if (g_i) q_ifu.push_back(ref_mem[ifu_req_addr]);
            if (!ifu_req_valid || g_i) starve = 0;
            else if (ok_i && starve < SMAX) starve++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
